// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared FSM encoding, direction indices and default timing for frogger_move_gen
package frogger_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // Bit positions inside the 4-bit debounced level / move vectors
    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;

    // Defaults for a 25 MHz clock
    localparam int c_DEF_DEBOUNCE_LIMIT = 250000;   // 10 ms
    localparam int c_DEF_REPEAT_DELAY   = 12500000; // 500 ms
    localparam int c_DEF_REPEAT_PERIOD  = 5000000;  // 200 ms

    // Fixed priority Up > Down > Left > Right for simultaneous presses
    function automatic logic [1:0] pick_owner(input logic [3:0] lvl);
        if (lvl[UP])        return 2'(UP);
        else if (lvl[DOWN]) return 2'(DOWN);
        else if (lvl[LEFT]) return 2'(LEFT);
        else                return 2'(RIGHT);
    endfunction

endpackage

// File: rtl/frogger_debounce.sv
// rtl/frogger_debounce.sv - 2-flop synchronizer plus counter debounce for one raw button
//
// Ports:
//   i_Clk     system clock
//   i_Rst_n   asynchronous active-low reset
//   i_Switch  raw button, asynchronous to i_Clk
//   o_Switch  debounced level
module frogger_debounce #(
    parameter int c_DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Switch,
    output logic o_Switch
);

    localparam int CW = $clog2(c_DEBOUNCE_LIMIT + 1);

    logic          sync_1;
    logic          sync_2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= i_Switch;
            sync_2 <= sync_1;
            if (sync_2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(c_DEBOUNCE_LIMIT - 1)) begin
                // This is the LIMIT-th consecutive differing sample: accept it
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign o_Switch = stable;

endmodule

// File: rtl/frogger_move_gen.sv
// rtl/frogger_move_gen.sv - turns four raw buttons into single-cycle frogger move commands
//
// Optional feature macro: FRG_AUTO_REPEAT_EN (hold auto-repeat; without it, one pulse per press)
//
// Ports:
//   i_Clk, i_Rst_n                         clock, asynchronous active-low reset
//   i_Switch_1..4                          raw Up/Down/Left/Right buttons
//   i_Enable                               1 = commands allowed
//   o_Up/Down/Left/Right_Mvt               one-cycle move commands (registered)
//   o_Btn_State                            debounced levels {Right,Left,Down,Up}
module frogger_move_gen
    import frogger_pkg::*;
#(
    parameter int c_DEBOUNCE_LIMIT = c_DEF_DEBOUNCE_LIMIT
`ifdef FRG_AUTO_REPEAT_EN
    ,
    parameter int c_REPEAT_DELAY   = c_DEF_REPEAT_DELAY,
    parameter int c_REPEAT_PERIOD  = c_DEF_REPEAT_PERIOD
`endif
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    input  logic       i_Enable,
    output logic       o_Up_Mvt,
    output logic       o_Down_Mvt,
    output logic       o_Left_Mvt,
    output logic       o_Right_Mvt,
    output logic [3:0] o_Btn_State
);

    logic [3:0] lvl;

    frogger_debounce #(.c_DEBOUNCE_LIMIT(c_DEBOUNCE_LIMIT)) u_db_up (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Switch(i_Switch_1), .o_Switch(lvl[UP]));
    frogger_debounce #(.c_DEBOUNCE_LIMIT(c_DEBOUNCE_LIMIT)) u_db_down (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Switch(i_Switch_2), .o_Switch(lvl[DOWN]));
    frogger_debounce #(.c_DEBOUNCE_LIMIT(c_DEBOUNCE_LIMIT)) u_db_left (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Switch(i_Switch_3), .o_Switch(lvl[LEFT]));
    frogger_debounce #(.c_DEBOUNCE_LIMIT(c_DEBOUNCE_LIMIT)) u_db_right (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Switch(i_Switch_4), .o_Switch(lvl[RIGHT]));

    state_t     state, state_next;
    logic [1:0] owner, owner_next;
    logic [3:0] mvt, mvt_next;

`ifdef FRG_AUTO_REPEAT_EN
    localparam int c_REPEAT_MAX = (c_REPEAT_DELAY > c_REPEAT_PERIOD) ? c_REPEAT_DELAY : c_REPEAT_PERIOD;
    localparam int RCW          = $clog2(c_REPEAT_MAX + 1);

    logic [RCW-1:0] rpt_cnt, rpt_next;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= IDLE;
            owner   <= 2'd0;
            mvt     <= 4'd0;
`ifdef FRG_AUTO_REPEAT_EN
            rpt_cnt <= '0;
`endif
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            mvt     <= mvt_next;
`ifdef FRG_AUTO_REPEAT_EN
            rpt_cnt <= rpt_next;
`endif
        end
    end

    // A pulse is only ever produced on a state change or from a counter that restarts at 0,
    // so two pulses can never land on consecutive cycles.
    always_comb begin
        state_next = state;
        owner_next = owner;
        mvt_next   = 4'd0;
`ifdef FRG_AUTO_REPEAT_EN
        rpt_next   = rpt_cnt;
`endif
        if (!i_Enable) begin
            // Anything held while disabled must be released before it can fire again
            state_next = WAIT_REL;
        end else begin
            case (state)
                IDLE: begin
                    if (|lvl) begin
                        owner_next           = pick_owner(lvl);
                        mvt_next[owner_next] = 1'b1;
                        state_next           = HOLD;
`ifdef FRG_AUTO_REPEAT_EN
                        rpt_next             = '0;
`endif
                    end
                end
                HOLD: begin
                    if (!lvl[owner]) begin
                        state_next = IDLE;
`ifdef FRG_AUTO_REPEAT_EN
                    end else if (rpt_cnt == RCW'(c_REPEAT_DELAY - 1)) begin
                        mvt_next[owner] = 1'b1;
                        state_next      = REPEAT;
                        rpt_next        = '0;
                    end else begin
                        rpt_next = rpt_cnt + RCW'(1);
`endif
                    end
                end
`ifdef FRG_AUTO_REPEAT_EN
                REPEAT: begin
                    if (!lvl[owner]) begin
                        state_next = IDLE;
                    end else if (rpt_cnt == RCW'(c_REPEAT_PERIOD - 1)) begin
                        mvt_next[owner] = 1'b1;
                        rpt_next        = '0;
                    end else begin
                        rpt_next = rpt_cnt + RCW'(1);
                    end
                end
`endif
                WAIT_REL: begin
                    if (lvl == 4'd0) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign o_Up_Mvt    = mvt[UP];
    assign o_Down_Mvt  = mvt[DOWN];
    assign o_Left_Mvt  = mvt[LEFT];
    assign o_Right_Mvt = mvt[RIGHT];
    assign o_Btn_State = lvl;

endmodule
